// File: rtl/mp_sched_pkg.sv
// Shared definitions for the max-pool line-buffer scheduler.
package mp_sched_pkg;

  localparam int unsigned DIM_W_DEF = 9;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FILL_E = 3'd1,
    S_FILL_O = 3'd2,
    S_DRAIN  = 3'd3,
    S_FLUSH  = 3'd4,
    S_DONE   = 3'd5
  } state_e;

endpackage

// File: rtl/mp_dim_counter.sv
// Dimension counter: counts enabled events up to a limit, then wraps to 0.
// last_o flags that the current count equals the limit.
module mp_dim_counter #(
  parameter int unsigned WIDTH = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en_i,
  input  logic             clr_i,
  input  logic [WIDTH-1:0] limit_i,
  output logic             last_o
);

  logic [WIDTH-1:0] count_q, count_d;

  assign last_o = (count_q == limit_i);

  // Next count: clear has priority, wrap to zero after the limit
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (en_i) begin
      count_d = last_o ? '0 : count_q + WIDTH'(1);
    end
  end

  // Count register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/mp_line_scheduler.sv
// Sequencer for the max-pool even/odd line-buffer BRAM pair: fills the even
// then odd bank with one row each, drains the pair into the pooling unit,
// and discards the trailing row of an odd-height frame.
module mp_line_scheduler
  import mp_sched_pkg::*;
#(
  parameter int unsigned DIM_W = DIM_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [DIM_W-1:0] ifm_width,
  input  logic [DIM_W-1:0] ifm_height,
  input  logic             s_valid,
  output logic             s_ready,
  output logic             wr_even,
  output logic             wr_odd,
  input  logic             full_even,
  input  logic             full_odd,
  output logic             rd_even,
  output logic             rd_odd,
  input  logic             pair_avail,
  input  logic             m_ready,
  output logic             m_valid,
  output logic             pair_done,
  output logic             busy,
  output logic             done
);

  state_e           state_q, state_d;
  logic [DIM_W-1:0] w_q, h_q;
  logic             m_valid_q;
  logic             start_acc, trivial, accept, rd_fire;
  logic             col_last, pair_last;

  assign start_acc = (state_q == S_IDLE) & start;
  assign trivial   = (ifm_width == '0) | (ifm_height < DIM_W'(2));
  assign accept    = s_valid & s_ready;
  assign rd_fire   = (state_q == S_DRAIN) & pair_avail & m_ready;
  assign m_valid   = m_valid_q;

  // Column counter shared by fill, drain and flush phases
  mp_dim_counter #(.WIDTH(DIM_W)) u_col (
    .clk     (clk),
    .rst     (rst),
    .en_i    (accept | rd_fire),
    .clr_i   (start_acc),
    .limit_i (w_q - DIM_W'(1)),
    .last_o  (col_last)
  );

  // Row-pair counter, advanced by the last read of each pair
  mp_dim_counter #(.WIDTH(DIM_W)) u_pair (
    .clk     (clk),
    .rst     (rst),
    .en_i    (rd_fire & col_last),
    .clr_i   (start_acc),
    .limit_i ((h_q >> 1) - DIM_W'(1)),
    .last_o  (pair_last)
  );

  // State register, frame dimensions and one-cycle read-latency tracker
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      m_valid_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      m_valid_q <= rd_fire;
      if (start_acc) begin
        w_q <= ifm_width;
        h_q <= ifm_height;
      end
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (start) state_d = trivial ? S_DONE : S_FILL_E;
      S_FILL_E: if (accept && col_last) state_d = S_FILL_O;
      S_FILL_O: if (accept && col_last) state_d = S_DRAIN;
      S_DRAIN: begin
        if (rd_fire && col_last) begin
          if (pair_last) state_d = h_q[0] ? S_FLUSH : S_DONE;
          else           state_d = S_FILL_E;
        end
      end
      S_FLUSH:  if (accept && col_last) state_d = S_DONE;
      S_DONE:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Output decode: handshakes and strobes per state
  always_comb begin
    s_ready   = 1'b0;
    wr_even   = 1'b0;
    wr_odd    = 1'b0;
    rd_even   = 1'b0;
    rd_odd    = 1'b0;
    pair_done = 1'b0;
    busy      = (state_q != S_IDLE) && (state_q != S_DONE);
    done      = (state_q == S_DONE);
    unique case (state_q)
      S_FILL_E: begin
        s_ready = !full_even;
        wr_even = s_valid & !full_even;
      end
      S_FILL_O: begin
        s_ready = !full_odd;
        wr_odd  = s_valid & !full_odd;
      end
      S_DRAIN: begin
        rd_even   = rd_fire;
        rd_odd    = rd_fire;
        pair_done = rd_fire & col_last;
      end
      S_FLUSH:  s_ready = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mp_line_scheduler.sv
// Scoreboard bench for mp_line_scheduler: each accepted frame is expanded into
// an ordered list of expected events; the monitor checks the outputs every
// cycle against the event at the head of that list.
module tb_mp_line_scheduler;

  localparam int unsigned DW = 9;
  localparam int K_WE = 1, K_WO = 2, K_RD = 3, K_FL = 4, K_DN = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [DW-1:0] ifm_width = '0, ifm_height = '0;
  logic          s_valid = 1'b0, full_even = 1'b0, full_odd = 1'b0;
  logic          pair_avail = 1'b0, m_ready = 1'b0;
  logic          s_ready, wr_even, wr_odd, rd_even, rd_odd;
  logic          m_valid, pair_done, busy, done;

  mp_line_scheduler #(.DIM_W(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .ifm_width  (ifm_width),
    .ifm_height (ifm_height),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .wr_even    (wr_even),
    .wr_odd     (wr_odd),
    .full_even  (full_even),
    .full_odd   (full_odd),
    .rd_even    (rd_even),
    .rd_odd     (rd_odd),
    .pair_avail (pair_avail),
    .m_ready    (m_ready),
    .m_valid    (m_valid),
    .pair_done  (pair_done),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int exp_q[$];
  int p_sv = 100, p_mr = 100, p_pa = 100, p_fe = 0, p_fo = 0;
  int force_mr = 0, force_fe = 0;
  int n_we = 0, n_wo = 0, n_rd = 0, n_mv = 0, n_pd = 0, n_done = 0, n_fl = 0;

  function automatic logic pct(int p);
    return ($urandom_range(99) < p);
  endfunction

  task automatic check(string name, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Random input driver, with forced stall windows
  initial begin
    forever begin
      @(posedge clk);
      #1;
      s_valid    = pct(p_sv);
      pair_avail = pct(p_pa);
      full_odd   = pct(p_fo);
      if (force_mr > 0) begin
        m_ready = 1'b0;
        force_mr--;
      end else begin
        m_ready = pct(p_mr);
      end
      if (force_fe > 0) begin
        full_even = 1'b1;
        force_fe--;
      end else begin
        full_even = pct(p_fe);
      end
    end
  end

  // Monitor: expected outputs follow from the event at the head of the list
  int          m_front, m_kind;
  logic        m_pd, m_fire, prev_rd = 1'b0;
  logic        e_sr, e_we, e_wo, e_rd, e_pdn, e_busy, e_done;
  logic [8:0]  e_vec, a_vec;
  always @(negedge clk) begin
    if (rst) begin
      prev_rd = 1'b0;
    end else begin
      m_front = (exp_q.size() > 0) ? exp_q[0] : 0;
      m_kind  = m_front / 2;
      m_pd    = (m_front % 2) == 1;
      e_sr = 0; e_we = 0; e_wo = 0; e_rd = 0; e_pdn = 0; e_done = 0; m_fire = 0;
      e_busy = (m_kind >= K_WE) && (m_kind <= K_FL);
      case (m_kind)
        K_WE: begin e_sr = !full_even; e_we = s_valid & e_sr; m_fire = e_we; end
        K_WO: begin e_sr = !full_odd;  e_wo = s_valid & e_sr; m_fire = e_wo; end
        K_RD: begin e_rd = pair_avail & m_ready; e_pdn = e_rd & m_pd; m_fire = e_rd; end
        K_FL: begin e_sr = 1'b1; m_fire = s_valid; end
        K_DN: begin e_done = 1'b1; m_fire = 1'b1; end
        default: ;
      endcase
      e_vec = {e_sr, e_we, e_wo, e_rd, e_rd, prev_rd, e_pdn, e_busy, e_done};
      a_vec = {s_ready, wr_even, wr_odd, rd_even, rd_odd, m_valid, pair_done, busy, done};
      tests++;
      if (a_vec !== e_vec) begin
        fails++;
        $display("FAIL cycle_outputs t=%0t: {srdy,we,wo,re,ro,mv,pd,busy,done} got %b expected %b",
                 $time, a_vec, e_vec);
      end
      if (m_fire) void'(exp_q.pop_front());
      prev_rd = e_rd;
      n_we   += int'(wr_even);
      n_wo   += int'(wr_odd);
      n_rd   += int'(rd_even);
      n_mv   += int'(m_valid);
      n_pd   += int'(pair_done);
      n_done += int'(done);
      n_fl   += int'(s_valid & s_ready & !wr_even & !wr_odd);
    end
  end

  // Issue a start in IDLE and expand the frame into its expected event list
  task automatic start_frame(int w, int h);
    @(posedge clk);
    #1;
    ifm_width  = DW'(w);
    ifm_height = DW'(h);
    start      = 1'b1;
    @(posedge clk);
    n_we = 0; n_wo = 0; n_rd = 0; n_mv = 0; n_pd = 0; n_done = 0; n_fl = 0;
    if (w == 0 || h < 2) begin
      exp_q.push_back(K_DN * 2);
    end else begin
      for (int p = 0; p < h / 2; p++) begin
        for (int i = 0; i < w; i++) exp_q.push_back(K_WE * 2);
        for (int i = 0; i < w; i++) exp_q.push_back(K_WO * 2);
        for (int i = 0; i < w; i++) exp_q.push_back(K_RD * 2 + ((i == w - 1) ? 1 : 0));
      end
      if (h % 2 == 1)
        for (int i = 0; i < w; i++) exp_q.push_back(K_FL * 2);
      exp_q.push_back(K_DN * 2);
    end
    #1;
    start = 1'b0;
  endtask

  task automatic wait_idle(int budget);
    int n = 0;
    while (exp_q.size() != 0 && n < budget) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("frame_timeout", exp_q.size(), 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    #1;
  endtask

  task automatic set_probs(int sv, int mr, int pa, int fe, int fo);
    p_sv = sv; p_mr = mr; p_pa = pa; p_fe = fe; p_fo = fo;
  endtask

  initial begin
    #2;
    check("reset_outputs",
          int'({s_ready, wr_even, wr_odd, rd_even, rd_odd, m_valid, pair_done, busy, done}), 0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // Full-throughput 4x4 frame
    set_probs(100, 100, 100, 0, 0);
    start_frame(4, 4);
    wait_idle(200);
    check("t1_wr_even", n_we, 8);
    check("t1_wr_odd", n_wo, 8);
    check("t1_reads", n_rd, 8);
    check("t1_pair_done", n_pd, 2);
    check("t1_done", n_done, 1);

    // Odd height: trailing row discarded
    start_frame(3, 5);
    wait_idle(200);
    check("t2_reads", n_rd, 6);
    check("t2_flushed", n_fl, 3);
    check("t2_wr_even", n_we, 6);
    check("t2_done", n_done, 1);

    // m_ready held low for three cycles mid-drain
    start_frame(4, 2);
    begin
      int n = 0;
      while (n_rd < 2 && n < 50) begin @(negedge clk); #1; n++; end
    end
    check("t3_reached_drain", n_rd, 2);
    force_mr = 3;
    repeat (3) @(negedge clk);
    #1;
    check("t3_no_read_while_stalled", n_rd, 2);
    wait_idle(200);
    check("t3_m_valid_total", n_mv, 4);
    check("t3_reads", n_rd, 4);

    // full_even high for two cycles mid-row
    start_frame(4, 2);
    begin
      int n = 0;
      while (n_we < 2 && n < 50) begin @(negedge clk); #1; n++; end
    end
    force_fe = 2;
    repeat (2) @(negedge clk);
    #1;
    check("t4_write_held", n_we, 2);
    wait_idle(200);
    check("t4_wr_even", n_we, 4);

    // Zero width: immediate done, no strobes
    start_frame(0, 4);
    wait_idle(5);
    check("t5_done", n_done, 1);
    check("t5_strobes", n_we + n_wo + n_rd + n_fl, 0);

    // Height 1: no pair possible
    start_frame(5, 1);
    wait_idle(5);
    check("t5b_strobes", n_we + n_wo + n_rd, 0);

    // Second start while busy, with dimension inputs changing
    set_probs(70, 80, 80, 20, 20);
    start_frame(5, 4);
    repeat (4) @(posedge clk);
    #1;
    ifm_width  = DW'(2);
    ifm_height = DW'(2);
    start      = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    wait_idle(1000);
    check("t6_reads", n_rd, 10);
    check("t6_done", n_done, 1);

    // Reset mid-drain aborts without done
    set_probs(100, 100, 100, 0, 0);
    start_frame(4, 2);
    begin
      int n = 0;
      while (n_rd < 1 && n < 50) begin @(negedge clk); #1; n++; end
    end
    @(posedge clk);
    #3 rst = 1'b1;
    exp_q.delete();
    #1;
    check("t7_outputs_in_reset",
          int'({s_ready, wr_even, wr_odd, rd_even, rd_odd, m_valid, pair_done, busy, done}), 0);
    @(posedge clk);
    #3 rst = 1'b0;
    n_done = 0;
    repeat (6) @(negedge clk);
    #1;
    check("t7_no_done", n_done, 0);

    // Randomized frames
    for (int f = 0; f < 20; f++) begin
      int w, h;
      w = ($urandom_range(9) == 0) ? 0 : int'($urandom_range(6, 1));
      h = int'($urandom_range(7));
      set_probs(int'($urandom_range(100, 30)), int'($urandom_range(100, 30)),
                int'($urandom_range(100, 30)), int'($urandom_range(40)),
                int'($urandom_range(40)));
      start_frame(w, h);
      ifm_width  = DW'($urandom);
      ifm_height = DW'($urandom);
      wait_idle(3000);
      check("rand_done", n_done, 1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
